// File: rtl/i2c_target_rx_if.sv
// Pin-side and core-side signals of the I2C target receive path.
// The slave modport is the target; the master modport is the pins/core side.
interface i2c_target_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       start_pulse;
    logic       stop_pulse;
    logic       busy;
    logic       overrun;

    modport slave (
        input  scl_in, sda_in, rx_ready,
        output sda_oe, rx_data, rx_valid, start_pulse, stop_pulse, busy, overrun
    );

    modport master (
        output scl_in, sda_in, rx_ready,
        input  sda_oe, rx_data, rx_valid, start_pulse, stop_pulse, busy, overrun
    );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receive path.
// Pins are oversampled on clk; received bytes go to the core over valid/ready.
module i2c_target_rx #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    i2c_target_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_h, sda_h;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_det, stop_det;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       ack_phase_q, ack_phase_d;
    logic       ack_q, ack_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;
    logic       start_pulse_q, stop_pulse_q;

    // Synchronizers and history flops preset to an idle (high) bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_h    <= scl_s;
            sda_h    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign sda_rise = sda_s & ~sda_h;
    assign sda_fall = ~sda_s & sda_h;

    // A simultaneous SCL edge masks the SDA edge: it is data movement, not a bus condition.
    assign start_det = sda_fall & scl_s & ~(scl_rise | scl_fall);
    assign stop_det  = sda_rise & scl_s & ~(scl_rise | scl_fall);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            shift_q       <= 8'h00;
            bit_cnt_q     <= 3'd0;
            ack_phase_q   <= 1'b0;
            ack_q         <= 1'b0;
            sda_oe_q      <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            start_pulse_q <= 1'b0;
            stop_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            ack_phase_q   <= ack_phase_d;
            ack_q         <= ack_d;
            sda_oe_q      <= sda_oe_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            start_pulse_q <= start_det;
            stop_pulse_q  <= stop_det;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ack_phase_d = ack_phase_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;

        // Acceptance is applied first so a same-cycle completing byte sees an empty slot.
        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (start_det) begin
            state_d     = ADDR;
            busy_d      = 1'b1;
            overrun_d   = 1'b0;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
        end else if (stop_det) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d   = 3'd0;
                            ack_phase_d = 1'b0;
                            if (state_q == ADDR) begin
                                ack_d   = 1'b1;
                                state_d = (shift_d[7:1] == TARGET_ADDR && !shift_d[0])
                                          ? ADDR_ACK : IGNORE;
                            end else begin
                                state_d = DATA_ACK;
                                if (rx_valid_q && !bus.rx_ready) begin
                                    overrun_d = 1'b1;
                                    ack_d     = 1'b0;
                                end else begin
                                    rx_data_d  = shift_d;
                                    rx_valid_d = 1'b1;
                                    ack_d      = 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // First SCL fall opens the ACK slot, the second closes it.
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            ack_phase_d = 1'b1;
                            sda_oe_d    = ack_q;
                        end else begin
                            ack_phase_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = DATA;
                        end
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe      = sda_oe_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.start_pulse = start_pulse_q;
    assign bus.stop_pulse  = stop_pulse_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: bit-banged I2C master plus a
// scoreboard of expected received bytes checked at each valid/ready handshake.
module tb_i2c_target_rx;

    localparam int unsigned Q = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    i2c_target_rx_if bus ();

    i2c_target_rx #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         hs_cnt    = 0;
    logic       oe_seen   = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor sampled on the falling edge; inputs change just after rising edges.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.start_pulse) start_cnt++;
            if (bus.stop_pulse)  stop_cnt++;
            if (bus.sda_oe)      oe_seen = 1'b1;
            if (bus.rx_valid && bus.rx_ready) begin
                hs_cnt++;
                check_eq("rx_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic i2c_start();
        bus.sda_in = 1'b1; wait_n(Q);
        bus.scl_in = 1'b1; wait_n(Q);
        bus.sda_in = 1'b0; wait_n(Q);
        bus.scl_in = 1'b0; wait_n(Q);
    endtask

    task automatic i2c_stop();
        bus.sda_in = 1'b0; wait_n(Q);
        bus.scl_in = 1'b1; wait_n(Q);
        bus.sda_in = 1'b1; wait_n(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bus.sda_in = b[i]; wait_n(Q);
            bus.scl_in = 1'b1; wait_n(Q);
            bus.scl_in = 1'b0; wait_n(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        bus.sda_in = 1'b1; wait_n(Q);
        bus.scl_in = 1'b1; wait_n(Q / 2);
        ack = bus.sda_oe;
        wait_n(Q / 2);
        bus.scl_in = 1'b0; wait_n(Q);
    endtask

    initial begin
        logic ack;
        int   s0, p0, h0;

        bus.scl_in   = 1'b1;
        bus.sda_in   = 1'b1;
        bus.rx_ready = 1'b0;
        wait_n(5);
        check_eq("rst_sda_oe",   32'(bus.sda_oe),      32'd0);
        check_eq("rst_rx_valid", 32'(bus.rx_valid),    32'd0);
        check_eq("rst_rx_data",  32'(bus.rx_data),     32'h00);
        check_eq("rst_busy",     32'(bus.busy),        32'd0);
        check_eq("rst_overrun",  32'(bus.overrun),     32'd0);
        check_eq("rst_start",    32'(bus.start_pulse), 32'd0);
        reset_n = 1'b1;
        wait_n(Q);

        // Addressed write of one byte with the core always ready.
        bus.rx_ready = 1'b1;
        s0 = start_cnt; p0 = stop_cnt; h0 = hs_cnt;
        i2c_start();
        check_eq("a_busy_on", 32'(bus.busy), 32'd1);
        check_eq("a_start_once", 32'(start_cnt - s0), 32'd1);
        send_byte(8'h84, ack);
        check_eq("a_addr_ack", 32'(ack), 32'd1);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, ack);
        check_eq("a_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        wait_n(Q);
        check_eq("a_busy_off", 32'(bus.busy), 32'd0);
        check_eq("a_stop_once", 32'(stop_cnt - p0), 32'd1);
        check_eq("a_start_total", 32'(start_cnt - s0), 32'd1);
        check_eq("a_hs_once", 32'(hs_cnt - h0), 32'd1);
        check_eq("a_valid_low", 32'(bus.rx_valid), 32'd0);

        // Foreign address: no ACK anywhere, data ignored.
        h0 = hs_cnt; oe_seen = 1'b0;
        i2c_start();
        send_byte(8'h86, ack);
        check_eq("b_addr_nack", 32'(ack), 32'd0);
        send_byte(8'h3C, ack);
        check_eq("b_data_nack", 32'(ack), 32'd0);
        send_byte(8'h5A, ack);
        check_eq("b_oe_never", 32'(oe_seen), 32'd0);
        check_eq("b_no_rx", 32'(hs_cnt - h0), 32'd0);
        i2c_stop();
        wait_n(Q);

        // Own address with read bit: NACK, then STOP.
        p0 = stop_cnt; oe_seen = 1'b0;
        i2c_start();
        send_byte(8'h85, ack);
        check_eq("c_read_nack", 32'(ack), 32'd0);
        i2c_stop();
        wait_n(Q);
        check_eq("c_stop_once", 32'(stop_cnt - p0), 32'd1);
        check_eq("c_busy_off", 32'(bus.busy), 32'd0);
        check_eq("c_oe_never", 32'(oe_seen), 32'd0);

        // Core stalled: second byte overruns, repeated START clears overrun only.
        bus.rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h84, ack);
        check_eq("d_addr_ack", 32'(ack), 32'd1);
        exp_q.push_back(8'h11);
        send_byte(8'h11, ack);
        check_eq("d_first_ack", 32'(ack), 32'd1);
        check_eq("d_valid_held", 32'(bus.rx_valid), 32'd1);
        check_eq("d_overrun_clr", 32'(bus.overrun), 32'd0);
        send_byte(8'h22, ack);
        check_eq("d_second_nack", 32'(ack), 32'd0);
        check_eq("d_overrun_set", 32'(bus.overrun), 32'd1);
        check_eq("d_data_kept", 32'(bus.rx_data), 32'h11);
        s0 = start_cnt;
        i2c_start();
        check_eq("d_rs_overrun", 32'(bus.overrun), 32'd0);
        check_eq("d_rs_start", 32'(start_cnt - s0), 32'd1);
        check_eq("d_rs_data", 32'(bus.rx_data), 32'h11);
        check_eq("d_rs_valid", 32'(bus.rx_valid), 32'd1);
        bus.rx_ready = 1'b1;
        wait_n(Q);
        check_eq("d_drained", 32'(bus.rx_valid), 32'd0);
        i2c_stop();
        wait_n(Q);

        // SCL and SDA moving in the same cycle with SCL high: no bus condition.
        s0 = start_cnt; p0 = stop_cnt;
        bus.scl_in = 1'b0; bus.sda_in = 1'b0; wait_n(Q);
        bus.scl_in = 1'b1; bus.sda_in = 1'b1; wait_n(Q);
        bus.scl_in = 1'b0; bus.sda_in = 1'b0; wait_n(Q);
        bus.scl_in = 1'b1; bus.sda_in = 1'b1; wait_n(Q);
        check_eq("e_no_start", 32'(start_cnt - s0), 32'd0);
        check_eq("e_no_stop", 32'(stop_cnt - p0), 32'd0);

        // Reset mid-address with SDA held low.
        i2c_start();
        send_bits(8'h84, 4);
        check_eq("f_busy_pre", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("f_rst_oe", 32'(bus.sda_oe), 32'd0);
        check_eq("f_rst_busy", 32'(bus.busy), 32'd0);
        wait_n(Q);
        reset_n = 1'b1;
        s0 = start_cnt;
        wait_n(2 * Q);
        check_eq("f_no_start", 32'(start_cnt - s0), 32'd0);
        check_eq("f_busy_idle", 32'(bus.busy), 32'd0);
        bus.sda_in = 1'b1; wait_n(Q);
        bus.scl_in = 1'b1; wait_n(Q);
        h0 = hs_cnt;
        i2c_start();
        send_byte(8'h84, ack);
        check_eq("f_reacq_ack", 32'(ack), 32'd1);
        exp_q.push_back(8'h5C);
        send_byte(8'h5C, ack);
        check_eq("f_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        wait_n(Q);
        check_eq("f_hs_once", 32'(hs_cnt - h0), 32'd1);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
